// File: rtl/ls194_sequencer.sv
// Step sequencer for an LS194-style 4-bit universal shift register.
// Loads a start pattern, then issues one shift command per prescaler tick.
module ls194_sequencer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int RUN_STEPS = 16
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic [3:0] pattern,
  output logic [1:0] ctrl,
  output logic [3:0] sw,
  output logic       shift,
  output logic       step_en,
  output logic [3:0] q_shadow,
  output logic [7:0] step_cnt,
  output logic       busy,
  output logic       done
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0] LIM = 8'(RUN_STEPS);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state;
  logic [1:0]    mode_l;
  logic [2:0]    phase;
  logic          dir;      // 0 = left, 1 = right
  logic [CW-1:0] cnt;

  logic [3:0] ld_sw;
  logic [1:0] nx_ctrl;
  logic       nx_shift;
  logic       nx_dir;
  logic [3:0] nx_q;

  always_comb begin
    case (mode)
      2'b10:   ld_sw = 4'b0001;
      2'b11:   ld_sw = 4'b0000;
      default: ld_sw = pattern;
    endcase
  end

  // Next step derived from the shadow copy, so no register feedback is needed.
  always_comb begin
    nx_dir   = dir;
    nx_shift = 1'b0;
    nx_ctrl  = 2'b01;
    case (mode_l)
      2'b00: nx_shift = q_shadow[3];
      2'b01: begin
        nx_ctrl  = 2'b10;
        nx_shift = q_shadow[0];
      end
      2'b10: begin
        if (!dir && q_shadow[3])     nx_dir = 1'b1;
        else if (dir && q_shadow[0]) nx_dir = 1'b0;
        nx_ctrl = nx_dir ? 2'b10 : 2'b01;
      end
      default: nx_shift = (phase < 3'd4);
    endcase
    nx_q = (nx_ctrl == 2'b10) ? {nx_shift, q_shadow[3:1]} : {q_shadow[2:0], nx_shift};
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_l   <= 2'b00;
      phase    <= 3'd0;
      dir      <= 1'b0;
      cnt      <= '0;
      ctrl     <= 2'b00;
      sw       <= 4'd0;
      shift    <= 1'b0;
      step_en  <= 1'b0;
      q_shadow <= 4'd0;
      step_cnt <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      step_en <= 1'b0;
      ctrl    <= 2'b00;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state    <= LOAD;
              mode_l   <= mode;
              step_en  <= 1'b1;
              ctrl     <= 2'b11;
              sw       <= ld_sw;
              q_shadow <= ld_sw;
              step_cnt <= 8'd0;
              phase    <= 3'd0;
              dir      <= 1'b0;
              cnt      <= '0;
              busy     <= 1'b1;
              done     <= 1'b0;
            end else if (state == DONE) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
          // The LOAD cycle counts as prescaler slot 0.
          LOAD: begin
            state <= RUN;
            cnt   <= CW'(1);
          end
          RUN: begin
            if (!pause) begin
              if (cnt == LAST) begin
                cnt      <= '0;
                step_en  <= 1'b1;
                ctrl     <= nx_ctrl;
                shift    <= nx_shift;
                q_shadow <= nx_q;
                dir      <= nx_dir;
                phase    <= phase + 3'd1;
                step_cnt <= step_cnt + 8'd1;
                if (RUN_STEPS != 0 && (step_cnt + 8'd1) == LIM) state <= DONE;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ls194_sequencer.md
# ls194_sequencer

Control sequencer for the 4-bit universal shift register (LS194-style: ctrl 00 hold, 11 parallel load, 01 shift left with serial-in at bit0, 10 shift right with serial-in at bit3). It loads a start pattern and then issues one shift command per prescaled tick to produce LED patterns: rotate, ping-pong and fill/clear. It runs in the 100 MHz domain. It drives the register's ctrl/data/serial-in inputs plus a one-cycle step enable. It keeps a shadow copy of the register contents so that rotate and bounce decisions need no feedback path.

## Interface
- TICK_DIV, 50_000_000, clk_100MHz cycles per step (≥2).
- RUN_STEPS, 16, shift steps per run after the load; 0 means run until stopped.
- clk_100MHz  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  single-cycle pulse, already synchronized
- stop  input  1  single-cycle pulse, already synchronized
- pause  input  1  level; freezes stepping while high
- mode  input  2  00 rotate-left, 01 rotate-right, 10 ping-pong, 11 fill/clear
- pattern  input  4  load value for modes 00/01
- ctrl  output  2  register control code
- sw  output  4  register parallel data
- shift  output  1  register serial input
- step_en  output  1  one-cycle strobe; register acts only when high
- q_shadow  output  4  value the register holds after the last step_en
- step_cnt  output  8  shift steps issued in the current run
- busy  output  1  high in LOAD/RUN
- done  output  1  high in DONE

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- **IDLE/DONE + start → LOAD.** On this transition, mode is latched. Changes to mode or pattern during the run are ignored.
- **LOAD lasts 1 cycle.** It issues step_en=1 with ctrl=11, then goes to RUN.
  - sw = pattern for modes 00/01.
  - sw = 4'b0001 for mode 10.
  - sw = 4'b0000 for mode 11.
  - q_shadow takes the value of sw. step_cnt, phase and dir are cleared (dir=left).
- **RUN.** Each prescaler tick while pause is low issues one step: step_en=1, step_cnt+1, and q_shadow is updated to the shifted value. The step depends on the latched mode:
  - 00: ctrl=01, shift=q_shadow[3] (rotate left).
  - 01: ctrl=10, shift=q_shadow[0] (rotate right).
  - 10: shift=0. If dir=left and q_shadow[3]=1, dir flips to right. If dir=right and q_shadow[0]=1, dir flips to left. The flip takes effect for this same step. Then ctrl=01 when dir=left, ctrl=10 when dir=right.
  - 11: ctrl=01, shift=(phase<4). The 3-bit phase increments each step and wraps 7→0.
- **RUN exit.** When RUN_STEPS≠0 and step_cnt reaches RUN_STEPS → DONE.
- **Between steps** ctrl=00 and step_en=0. sw and shift hold their last value.
- **stop** in any state → IDLE next cycle, with no step_en that cycle. stop wins over start and over a tick in the same cycle. q_shadow and step_cnt hold their values.
- start in LOAD or RUN is ignored.
- In DONE, done=1 until start or stop.

## Timing
- All outputs are registered.
- Reset values: ctrl=00, sw=0, shift=0, step_en=0, q_shadow=0, step_cnt=0, busy=0, done=0, FSM=IDLE.
- start at cycle N → LOAD step_en at N+1. busy rises at N+1.
- Prescaler:
  - Cleared in LOAD and counts 0..TICK_DIV-1 in RUN.
  - The tick fires when the count equals TICK_DIV-1 and the count wraps to 0.
  - The first shift step_en comes exactly TICK_DIV cycles after the LOAD step_en. Steps are TICK_DIV apart.
- pause high freezes the prescaler and blocks the tick. Release resumes from the frozen count.
- The final step_en and the entry to DONE happen in the same cycle: busy falls and done rises in the cycle after the last step_en.
- ctrl, sw and shift are valid in the step_en cycle. The register samples them on the clock edge that ends that cycle.
- Async reset mid-run: all outputs go to their reset values immediately, and no partial step is issued.

## Test plan
- **Rotate-left:** TICK_DIV=4, RUN_STEPS=4, mode=00, pattern=1000, start → LOAD ctrl=11/sw=1000. Then q_shadow 0001, 0010, 0100, 1000 with step_en every 4 cycles, then done=1, busy=0.
- **Ping-pong:** mode=10, RUN_STEPS=8 → q_shadow 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100 (load then 8 steps); ctrl goes 01×3, 10×3, 01×2.
- **Fill/clear:** mode=11, RUN_STEPS=8 → q_shadow 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
- **Pause:** mode=01, pattern=0001, pause held 10 cycles mid-interval → the next step_en is delayed by exactly 10 cycles and q_shadow continues 1000, 0100.
- **Stop and simultaneous events:**
  - stop asserted on a tick cycle → no step_en, IDLE, busy=0, step_cnt held.
  - start+stop in the same cycle from IDLE → stays IDLE.
- **RUN_STEPS=0:** runs past 255 steps, step_cnt wraps 255→0, and the run continues until stop.
